add_sub_4bit: RTL and testbench

Combinational 4-bit two's-complement adder/subtractor with signed-overflow detection. It is the arithmetic core of the 4-bit ALU. The ALU reads `Sum`/`Ovfl` directly for its add (opcode 00) and subtract (opcode 01) operations and drives `sub` from opcode bit 0. A small clocked flag register captures Zero/Overflow/Negative status of the current result for downstream condition logic.

---
 rtl/add_sub_4bit_if.sv | 25 ++
 rtl/add_sub_4bit.sv | 58 +++++
 tb/tb_add_sub_4bit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/add_sub_4bit_if.sv
// Operand/result bundle for the 4-bit adder/subtractor core.
// The master drives operands and control; the slave returns results and flags.
interface add_sub_4bit_if;
    logic [3:0] A;
    logic [3:0] B;
    logic       sub;
    logic       flag_en;
    logic [3:0] Sum;
    logic       Ovfl;
    logic       Cout;
    logic       Zero;
    logic       Z_flag;
    logic       V_flag;
    logic       N_flag;

    modport master (
        output A, B, sub, flag_en,
        input  Sum, Ovfl, Cout, Zero, Z_flag, V_flag, N_flag
    );

    modport slave (
        input  A, B, sub, flag_en,
        output Sum, Ovfl, Cout, Zero, Z_flag, V_flag, N_flag
    );
endinterface

// File: rtl/add_sub_4bit.sv
// 4-bit two's-complement add/subtract with carry-lookahead and signed overflow.
// A small flag register captures Zero/Overflow/Negative when flag_en is set.
module add_sub_4bit (
    input logic          clk,
    input logic          rst,
    add_sub_4bit_if.slave bus
);
    logic [3:0] bx, g, p;
    logic [4:0] c;
    logic       z_q, v_q, n_q;
    logic       z_d, v_d, n_d;

    // Subtract is A + ~B + 1: invert B and feed sub in as carry-in.
    assign bx = bus.B ^ {4{bus.sub}};
    assign g  = bus.A & bx;
    assign p  = bus.A ^ bx;

    assign c[0] = bus.sub;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign bus.Sum  = p ^ c[3:0];
    assign bus.Cout = c[4];
    assign bus.Ovfl = c[3] ^ c[4];
    assign bus.Zero = ~|bus.Sum;

    always_comb begin
        z_d = z_q;
        v_d = v_q;
        n_d = n_q;
        if (bus.flag_en) begin
            z_d = bus.Zero;
            v_d = bus.Ovfl;
            n_d = bus.Sum[3];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    assign bus.Z_flag = z_q;
    assign bus.V_flag = v_q;
    assign bus.N_flag = n_q;
endmodule

// File: tb/tb_add_sub_4bit.sv
// Scoreboard bench for add_sub_4bit: directed vectors, exhaustive sweep, flag/reset sequence.
module tb_add_sub_4bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stb = 1'b0;

    add_sub_4bit_if bus ();

    add_sub_4bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] sum;
        logic       ovfl;
        logic       cout;
        logic       zero;
        logic       zf;
        logic       vf;
        logic       nf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;
    logic ezf = 1'b0, evf = 1'b0, enf = 1'b0;

    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic s, input logic fe);
        bus.A = a; bus.B = b; bus.sub = s; bus.flag_en = fe;
    endtask

    task automatic expect_now(input logic [3:0] sum, input logic ov,
                              input logic co, input logic z);
        exp_t e;
        e.id = next_id; e.sum = sum; e.ovfl = ov; e.cout = co; e.zero = z;
        e.zf = ezf; e.vf = evf; e.nf = enf;
        next_id++;
        q.push_back(e);
        stb = 1'b1;
        #1 stb = 1'b0;
    endtask

    // Monitor: each strobe marks a point where DUT outputs are presented.
    initial begin
        exp_t e;
        forever begin
            @(posedge stb);
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({bus.Sum, bus.Ovfl, bus.Cout, bus.Zero} !== {e.sum, e.ovfl, e.cout, e.zero}) begin
                    errors++;
                    $display("FAIL arith #%0d A=%h B=%h sub=%b: got Sum=%h Ovfl=%b Cout=%b Zero=%b, want Sum=%h Ovfl=%b Cout=%b Zero=%b",
                             e.id, bus.A, bus.B, bus.sub, bus.Sum, bus.Ovfl, bus.Cout, bus.Zero,
                             e.sum, e.ovfl, e.cout, e.zero);
                end
                checks++;
                if ({bus.Z_flag, bus.V_flag, bus.N_flag} !== {e.zf, e.vf, e.nf}) begin
                    errors++;
                    $display("FAIL flags #%0d: got ZVN=%b%b%b, want ZVN=%b%b%b",
                             e.id, bus.Z_flag, bus.V_flag, bus.N_flag, e.zf, e.vf, e.nf);
                end
            end
        end
    end

    initial begin
        int rs;
        logic [3:0] rsum;
        logic rov, rco;

        drive(4'h0, 4'h0, 1'b0, 1'b0);
        #2 expect_now(4'h0, 1'b0, 1'b0, 1'b1);            // reset state
        @(negedge clk) rst = 1'b0;

        // Directed arithmetic vectors, one per cycle, sampled mid-cycle.
        @(negedge clk) drive(4'h7, 4'h1, 1'b0, 1'b0); #2 expect_now(4'h8, 1'b1, 1'b0, 1'b0);
        @(negedge clk) drive(4'h8, 4'hF, 1'b0, 1'b0); #2 expect_now(4'h7, 1'b1, 1'b1, 1'b0);
        @(negedge clk) drive(4'hF, 4'h1, 1'b0, 1'b0); #2 expect_now(4'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk) drive(4'h0, 4'h1, 1'b1, 1'b0); #2 expect_now(4'hF, 1'b0, 1'b0, 1'b0);
        @(negedge clk) drive(4'h7, 4'h8, 1'b1, 1'b0); #2 expect_now(4'hF, 1'b1, 1'b0, 1'b0);
        @(negedge clk) drive(4'h8, 4'h1, 1'b1, 1'b0); #2 expect_now(4'h7, 1'b1, 1'b1, 1'b0);

        // Exhaustive sweep against an integer reference and the sign rule.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int s = 0; s < 2; s++) begin
                    rs   = (s != 0) ? (a - b) : (a + b);
                    rsum = rs[3:0];
                    rco  = (s != 0) ? (a >= b) : ((a + b) > 15);
                    if (s == 0) rov = (a[3] == b[3]) && (rsum[3] != a[3]);
                    else        rov = (a[3] != b[3]) && (rsum[3] != a[3]);
                    @(negedge clk) drive(a[3:0], b[3:0], s[0], 1'b0);
                    #2 expect_now(rsum, rov, rco, (rsum == 4'h0));
                end

        // Flag capture, hold, and recapture.
        @(negedge clk) drive(4'h3, 4'h3, 1'b1, 1'b1);
        @(posedge clk) #1;
        ezf = 1'b1; evf = 1'b0; enf = 1'b0;
        expect_now(4'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk) drive(4'h7, 4'h1, 1'b0, 1'b0);
        @(posedge clk) #1 expect_now(4'h8, 1'b1, 1'b0, 1'b0);
        @(negedge clk) bus.flag_en = 1'b1;
        @(posedge clk) #1;
        ezf = 1'b0; evf = 1'b1; enf = 1'b1;
        drive(4'h0, 4'h0, 1'b0, 1'b0);                    // change right after the edge
        #1 expect_now(4'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk) #1 expect_now(4'h0, 1'b0, 1'b0, 1'b1);

        // Async reset between edges, then held across an enabled edge.
        @(negedge clk) drive(4'h7, 4'h1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        ezf = 1'b0; evf = 1'b0; enf = 1'b0;
        #1 expect_now(4'h8, 1'b1, 1'b0, 1'b0);
        @(negedge clk) drive(4'h3, 4'h3, 1'b1, 1'b1);
        @(posedge clk) #1 expect_now(4'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk) begin rst = 1'b0; bus.flag_en = 1'b0; end
        @(posedge clk) #1 expect_now(4'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk) bus.flag_en = 1'b1;
        @(posedge clk) #1;
        ezf = 1'b1; evf = 1'b0; enf = 1'b0;
        expect_now(4'h0, 1'b0, 1'b1, 1'b1);

        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
